// File: rtl/rep_div_seq.sv
// Sequential restoring divider for the replicated operand.
// One quotient bit per clock, valid/ready on both sides.
module rep_div_seq #(
   parameter int DW = 6,
   parameter int VW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          div_zero
);

   localparam int CW = $clog2(DW);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t        state;
   logic [DW-1:0] dvd;
   logic [VW:0]   prem;
   logic [VW-1:0] dvs;
   logic [CW-1:0] cnt;
   logic [VW:0]   trial;
   logic          ge;

   always_comb begin
      trial = {prem[VW-1:0], dvd[DW-1]};
      ge    = (trial >= {1'b0, dvs});
   end

   // dividend bits shift out the top while quotient bits shift in below
   assign quotient  = dvd;
   assign remainder = prem[VW-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         dvd       <= '0;
         prem      <= '0;
         dvs       <= '0;
         cnt       <= '0;
         div_zero  <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  dvs      <= divisor;
                  prem     <= '0;
                  in_ready <= 1'b0;
                  if (divisor == '0) begin
                     dvd       <= '1;
                     div_zero  <= 1'b1;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     dvd      <= dividend;
                     div_zero <= 1'b0;
                     cnt      <= CW'(DW - 1);
                     state    <= CALC;
                  end
               end
            end
            CALC: begin
               prem <= ge ? (trial - {1'b0, dvs}) : trial;
               dvd  <= {dvd[DW-2:0], ge};
               if (cnt == '0) begin
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rep_div_seq.sv
// Directed and exhaustive bench for rep_div_seq.
// Expected results are queued at accept and popped at out_valid.
module tb_rep_div_seq;

   localparam int DW = 6;
   localparam int VW = 4;

   typedef struct packed {
      logic          dz;
      logic [DW-1:0] q;
      logic [VW-1:0] r;
   } res_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] dividend;
   logic [VW-1:0] divisor;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          div_zero;

   int   tests = 0;
   int   fails = 0;
   res_t sb[$];

   rep_div_seq #(.DW(DW), .VW(VW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic res_t model(input logic [DW-1:0] a,
                                  input logic [VW-1:0] b);
      res_t m;
      if (b == '0) begin
         m = '{dz: 1'b1, q: '1, r: '0};
      end else begin
         m.dz = 1'b0;
         m.q  = DW'(a / b);
         m.r  = VW'(a % b);
      end
      return m;
   endfunction

   // one full transaction; latency counted as edges after the accept edge
   task automatic op(input logic [DW-1:0] a, input logic [VW-1:0] b,
                     input res_t e, input int hold);
      int   n;
      res_t got;
      res_t exp_r;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_wait", in_ready, 1);
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      dividend = DW'($urandom);
      divisor  = VW'($urandom);
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("latency", n, (b == '0) ? 0 : DW);
      got = {div_zero, quotient, remainder};
      if (sb.size() > 0) exp_r = sb.pop_front();
      else exp_r = '0;
      check("result", got, exp_r);
      out_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
         if (i == 1) begin
            in_valid = 1'b1;
            dividend = 6'd9;
            divisor  = 4'd2;
         end
         @(negedge clk);
         check("hold_stable", {out_valid, div_zero, quotient, remainder},
               {1'b1, exp_r});
         check("hold_in_ready", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check("release_valid", out_valid, 0);
      check("release_ready", in_ready, 1);
   endtask

   initial begin
      int   seen;
      int   off;
      int   idx;
      logic [DW-1:0] a;
      logic [VW-1:0] b;

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out", {out_valid, div_zero, quotient, remainder}, 0);
      rst = 1'b0;

      op(6'd21, 4'd4,  '{dz: 1'b0, q: 6'd5,  r: 4'd1},  0);
      op(6'd63, 4'd7,  '{dz: 1'b0, q: 6'd9,  r: 4'd0},  0);
      op(6'd63, 4'd1,  '{dz: 1'b0, q: 6'd63, r: 4'd0},  0);
      op(6'd42, 4'd15, '{dz: 1'b0, q: 6'd2,  r: 4'd12}, 0);
      op(6'd0,  4'd9,  '{dz: 1'b0, q: 6'd0,  r: 4'd0},  0);
      op(6'd21, 4'd0,  '{dz: 1'b1, q: 6'd63, r: 4'd0},  0);
      op(6'd21, 4'd4,  '{dz: 1'b0, q: 6'd5,  r: 4'd1},  0);

      // backpressure with a stray in_valid while DONE
      op(6'd42, 4'd15, '{dz: 1'b0, q: 6'd2,  r: 4'd12}, 5);
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("stray_not_captured", seen, 0);

      // reset while calculating
      while (!in_ready) @(negedge clk);
      dividend = 6'd42;
      divisor  = 4'd15;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midcalc_out", {out_valid, div_zero, quotient, remainder}, 0);
      check("midcalc_in_ready", in_ready, 0);
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("midcalc_no_result", seen, 0);
      op(6'd42, 4'd15, '{dz: 1'b0, q: 6'd2, r: 4'd12}, 0);

      // every dividend/divisor pair, from a random starting point
      off = int'($urandom_range(0, 1023));
      for (int i = 0; i < 1024; i++) begin
         idx = (i + off) % 1024;
         a   = DW'(idx >> 4);
         b   = VW'(idx);
         op(a, b, model(a, b), 0);
      end

      check("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
